prog_launcher: RTL
==================

# prog_launcher

Host-side sequencer that drives the processor's `Start` input and watches its `Done` output, so one or more programs run back-to-back without testbench hand-timing. On a `Go` request it launches program 0, holds `Start` for a fixed number of cycles, and counts cycles until `Done`. It reports that count, then moves on to the next program until all `NUM_PROGS` have run. It sits between the top-level testbench/host and the processor core, at the opposite end of the `Start`/`Done` protocol from the program counter.

## Interface
- `NUM_PROGS`, default 3: number of programs launched per `Go`; range 1..4.
- `START_HOLD`, default 2: cycles `Start` is held high per launch; must be ≥1.
- `CNT_W`, default 16: width of the cycle counter.
- `TIMEOUT_CYC`, default 4096: watchdog limit in cycles; used only when the timeout feature is compiled in.
- `Clk  input  1`: clock; all state changes on the posedge.
- `Reset  input  1`: asynchronous, active-high reset.
- `Go  input  1`: launch request; sampled in IDLE only.
- `Done  input  1`: processor's program-complete flag; level signal.
- `Start  output  1`: to the processor's `Start` input.
- `ProgIdx  output  2`: index of the program currently or most recently launched.
- `CycleCount  output  CNT_W`: cycle count latched for the last completed program.
- `CountValid  output  1`: one-cycle pulse when `CycleCount` updates.
- `Busy  output  1`: high in every state except IDLE.
- `AllDone  output  1`: high in FIN; stays high until the next `Go` or reset.
- `TimedOut  output  1`: sticky; set if any program hit the watchdog.

## Operation
- Reset value of every output is 0; state is IDLE; internal counters are 0.
- IDLE:
  - `Go`=1 → LAUNCH, with `ProgIdx`←0 and hold counter←0.
  - `TimedOut` and `AllDone` clear on this transition.
- LAUNCH:
  - `Start`=1, registered output.
  - Hold counter increments each cycle; after `START_HOLD` cycles → RUN.
  - Cycle counter←0 on entry to RUN.
  - `Done` is ignored in LAUNCH, because the processor stalls while `Start` is high.
- RUN:
  - `Start`=0; cycle counter increments each cycle, saturating at all-ones.
  - `Done`=1 sampled → `CycleCount`←counter value including the current cycle, `CountValid` pulses, → GAP.
- GAP: exactly one cycle with `Start`=0, so the processor sees a distinct falling/rising pair.
  - If `ProgIdx`==`NUM_PROGS`-1 → FIN.
  - Otherwise `ProgIdx`+1 → LAUNCH.
- FIN:
  - `AllDone`=1.
  - `Go`=1 → LAUNCH with `ProgIdx`←0, clearing `AllDone` and `TimedOut`.
- Arithmetic: counters are unsigned; `ProgIdx` never exceeds `NUM_PROGS`-1; the cycle counter does not wrap.
- Simultaneous events:
  - `Go` outside IDLE/FIN is ignored.
  - `Done` and timeout in the same RUN cycle: `Done` wins and `TimedOut` is not set.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0, including `Start`.

## Timing
- `Start` rises one cycle after `Go` is sampled high in IDLE.
- `Start` stays high for exactly `START_HOLD` cycles.
- `CountValid` and `CycleCount` update on the edge that samples `Done`, i.e. 1-cycle latency from `Done`.
- Launch-to-launch overhead between programs: 1 (GAP) cycle plus `START_HOLD`.
- All outputs are registered; no combinational path from input to output.

## Configuration
- `PROG_LAUNCHER_TIMEOUT_EN` defined:
  - In RUN, when the cycle counter reaches `TIMEOUT_CYC`-1 without `Done`, the block behaves as if `Done` arrived.
  - `CycleCount` is latched with `TIMEOUT_CYC`, `CountValid` pulses, `TimedOut` is set (sticky), and the block proceeds to GAP.
- Not defined: no watchdog; RUN waits indefinitely; `TimedOut` is tied to 0; `TIMEOUT_CYC` is unused.

## Structure
- Shared package `launcher_pkg` holds the state enum (IDLE, LAUNCH, RUN, GAP, FIN) and the `PROG_IDX_W`=2 constant.
- No sub-module is required. Counters and the FSM live in `prog_launcher`.

## Test plan
- Reset, then `Go` pulse with `START_HOLD`=2, `NUM_PROGS`=1, `Done` asserted 10 cycles after `Start` falls → `Start` high cycles 1–2, `CycleCount`=10, one `CountValid` pulse, `AllDone`=1.
- `NUM_PROGS`=3 with `Done` after 5, 7 and 3 cycles → `ProgIdx` steps 0,1,2; `CycleCount` reads 5, 7, 3; exactly 3 `Start` pulses, each 2 cycles long and separated by ≥1 low cycle.
- `Done` held high during LAUNCH → ignored; counting starts in RUN and `CycleCount` reflects only RUN cycles.
- Reset asserted in RUN at cycle 4 → `Start`, `Busy` and `CountValid` all 0 on the next edge; state IDLE; subsequent `Go` restarts at `ProgIdx`=0.
- With `PROG_LAUNCHER_TIMEOUT_EN`, `TIMEOUT_CYC`=16, `Done` never asserted → `CycleCount`=16, `TimedOut`=1, the next program still launches; the next `Go` clears `TimedOut`.
- `Go` pulsed while `Busy` → no effect on `ProgIdx` or the `Start` sequence.

Source files
------------

// File: rtl/launcher_pkg.sv
// launcher_pkg: definitions shared by the program launcher and its interface.
//   - state_t / S_* : launcher FSM state encoding (IDLE, LAUNCH, RUN, GAP, FIN)
//   - PROG_IDX_W    : width of the program index
package launcher_pkg;

  localparam int unsigned PROG_IDX_W = 2;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LAUNCH = 3'd1;
  localparam state_t S_RUN    = 3'd2;
  localparam state_t S_GAP    = 3'd3;
  localparam state_t S_FIN    = 3'd4;

endpackage

// File: rtl/prog_launcher_if.sv
// prog_launcher_if: host/processor handshake bundle around the launcher.
//   Go         host -> launcher   launch request
//   Done       core -> launcher   program-complete level
//   Start      launcher -> core   start strobe
//   ProgIdx    launcher -> host   current / last program index
//   CycleCount launcher -> host   cycles spent by last program
//   CountValid launcher -> host   one-cycle update strobe for CycleCount
//   Busy, AllDone, TimedOut       launcher status
// Modports: master = launcher side, slave = host/core side.
interface prog_launcher_if
  import launcher_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  logic                  Go;
  logic                  Done;
  logic                  Start;
  logic [PROG_IDX_W-1:0] ProgIdx;
  logic [CNT_W-1:0]      CycleCount;
  logic                  CountValid;
  logic                  Busy;
  logic                  AllDone;
  logic                  TimedOut;

  modport master (
    input  Go, Done,
    output Start, ProgIdx, CycleCount, CountValid, Busy, AllDone, TimedOut
  );

  modport slave (
    output Go, Done,
    input  Start, ProgIdx, CycleCount, CountValid, Busy, AllDone, TimedOut
  );
endinterface

// File: rtl/prog_launcher.sv
// prog_launcher: runs NUM_PROGS programs back-to-back on the processor.
// For each program it holds Start high for START_HOLD cycles, counts the
// cycles until Done, reports the count, then leaves one idle cycle before
// the next launch.
// Ports:
//   Clk   : clock, rising edge
//   Reset : asynchronous active-high reset
//   bus   : prog_launcher_if.master (Go/Done in, status and Start out)
// Build option: define PROG_LAUNCHER_TIMEOUT_EN to enable the RUN watchdog
// (TIMEOUT_CYC cycles); otherwise RUN waits for Done forever and TimedOut
// stays 0.
module prog_launcher
  import launcher_pkg::*;
#(
  parameter int unsigned NUM_PROGS   = 3,
  parameter int unsigned START_HOLD  = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic             Clk,
  input  logic             Reset,
  prog_launcher_if.master  bus
);

  localparam int unsigned           HOLD_W    = $clog2(START_HOLD + 1);
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(START_HOLD - 1);
  localparam logic [PROG_IDX_W-1:0] LAST_IDX  = PROG_IDX_W'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0]      TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]      TO_COUNT  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};
`ifdef PROG_LAUNCHER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  state_t                state_r;
  state_t                state_nxt_s;
  logic [HOLD_W-1:0]     hold_cnt_r;
  logic [CNT_W-1:0]      cyc_cnt_r;
  logic [CNT_W-1:0]      cnt_inc_s;
  logic [PROG_IDX_W-1:0] prog_idx_r;
  logic [CNT_W-1:0]      cycle_count_r;
  logic                  count_valid_r;
  logic                  start_r;
  logic                  busy_r;
  logic                  all_done_r;
  logic                  timed_out_r;
  logic                  done_hit_s;
  logic                  timeout_hit_s;
  logic                  go_accept_s;

  // Done counts only in RUN; the core is stalled while Start is high.
  assign done_hit_s    = (state_r == S_RUN) && bus.Done;
  // Watchdog fires only when Done is absent, so Done wins a tie.
  assign timeout_hit_s = TO_EN && (state_r == S_RUN) && !bus.Done && (cyc_cnt_r == TO_LAST);
  assign go_accept_s   = ((state_r == S_IDLE) || (state_r == S_FIN)) && bus.Go;
  // Count including the current cycle, saturating instead of wrapping.
  assign cnt_inc_s     = (cyc_cnt_r == CNT_MAX) ? CNT_MAX : (cyc_cnt_r + CNT_W'(1));

  // Next-state logic of the launch sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.Go) state_nxt_s = S_LAUNCH;
        else        state_nxt_s = S_IDLE;
      end
      S_LAUNCH: begin
        if (hold_cnt_r == HOLD_LAST) state_nxt_s = S_RUN;
        else                         state_nxt_s = S_LAUNCH;
      end
      S_RUN: begin
        if (done_hit_s || timeout_hit_s) state_nxt_s = S_GAP;
        else                             state_nxt_s = S_RUN;
      end
      S_GAP: begin
        if (prog_idx_r == LAST_IDX) state_nxt_s = S_FIN;
        else                        state_nxt_s = S_LAUNCH;
      end
      S_FIN: begin
        if (bus.Go) state_nxt_s = S_LAUNCH;
        else        state_nxt_s = S_FIN;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register and state-decoded registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r    <= S_IDLE;
      start_r    <= 1'b0;
      busy_r     <= 1'b0;
      all_done_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      start_r    <= (state_nxt_s == S_LAUNCH);
      busy_r     <= (state_nxt_s != S_IDLE);
      all_done_r <= (state_nxt_s == S_FIN);
    end
  end

  // Start-hold and RUN cycle counters; both sit at 0 outside their state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_cnt_r <= '0;
      cyc_cnt_r  <= '0;
    end else begin
      if (state_r == S_LAUNCH) hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
      else                     hold_cnt_r <= '0;
      if (state_r == S_RUN) cyc_cnt_r <= cnt_inc_s;
      else                  cyc_cnt_r <= '0;
    end
  end

  // Program index: cleared by an accepted Go, advanced in GAP.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prog_idx_r <= '0;
    end else if (go_accept_s) begin
      prog_idx_r <= '0;
    end else if ((state_r == S_GAP) && (prog_idx_r != LAST_IDX)) begin
      prog_idx_r <= prog_idx_r + PROG_IDX_W'(1);
    end else begin
      prog_idx_r <= prog_idx_r;
    end
  end

  // Result capture, update strobe and sticky watchdog flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cycle_count_r <= '0;
      count_valid_r <= 1'b0;
      timed_out_r   <= 1'b0;
    end else begin
      count_valid_r <= done_hit_s || timeout_hit_s;
      if (done_hit_s)         cycle_count_r <= cnt_inc_s;
      else if (timeout_hit_s) cycle_count_r <= TO_COUNT;
      else                    cycle_count_r <= cycle_count_r;
      if (go_accept_s)        timed_out_r <= 1'b0;
      else if (timeout_hit_s) timed_out_r <= 1'b1;
      else                    timed_out_r <= timed_out_r;
    end
  end

  assign bus.Start      = start_r;
  assign bus.ProgIdx    = prog_idx_r;
  assign bus.CycleCount = cycle_count_r;
  assign bus.CountValid = count_valid_r;
  assign bus.Busy       = busy_r;
  assign bus.AllDone    = all_done_r;
  assign bus.TimedOut   = timed_out_r;

endmodule
